// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions for the classifier register block and master-side benches.
// Contents: HTRANS/HSIZE encodings, register offsets inside the 64 KiB window,
// responder FSM state type and decoded access kind.
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_BUSY = 2'b01;
   localparam logic [1:0] HTRANS_NSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ  = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [15:0] OFF_CTRL   = 16'h0000;
   localparam logic [15:0] OFF_CFG    = 16'h0004;
   localparam logic [15:0] OFF_STATUS = 16'h1000;
   localparam logic [15:0] OFF_RESULT = 16'h1004;
   // Pixel buffers occupy 0x2000-0x2BFF; haddr[11:10] selects R/G/B.
   localparam logic [3:0]  PIX_REGION = 4'h2;

   typedef enum logic [2:0] {
      StIdle,
      StWrData,
      StRdReg,
      StRdPix,
      StErr1,
      StErr2
   } ahb_state_e;

   typedef enum logic [2:0] {
      AccCtrl,
      AccCfg,
      AccStatus,
      AccResult,
      AccPix,
      AccBad
   } acc_kind_e;

endpackage

// File: rtl/ahb_classifier_regs.sv
// AHB-Lite single-slave responder for the ASL classifier core.
// Decodes single NSEQ transfers into CTRL/CFG/STATUS/RESULT registers and a byte-wide
// pixel port onto the core's three 32x32 R/G/B buffers.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ahb_*                   AHB-Lite slave interface (hsize ignored, word accesses)
//   start_o, cfg_o          inference start pulse, CFG register
//   done_i, label_i         inference-complete pulse and result label
//   pix_*                   pixel buffer write/read port (read data one cycle after pix_re_o)
module ahb_classifier_regs
   import ahb_lite_pkg::*;
#(
   parameter logic [15:0] BASE_HI = 16'h8000,
   parameter int unsigned LABEL_W = 5,
   parameter int unsigned PIX_AW  = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        ahb_haddr_i,
   input  logic               ahb_hwrite_i,
   input  logic [1:0]         ahb_htrans_i,
   input  logic [2:0]         ahb_hsize_i,
   input  logic [31:0]        ahb_hwdata_i,
   output logic               ahb_hready_o,
   output logic               ahb_hresp_o,
   output logic [31:0]        ahb_hrdata_o,
   output logic               start_o,
   output logic [31:0]        cfg_o,
   input  logic               done_i,
   input  logic [LABEL_W-1:0] label_i,
   output logic               pix_we_o,
   output logic               pix_re_o,
   output logic [1:0]         pix_ch_o,
   output logic [PIX_AW-1:0]  pix_addr_o,
   output logic [7:0]         pix_wdata_o,
   input  logic [7:0]         pix_rdata_i
);

   function automatic acc_kind_e decode(input logic [31:0] a);
      acc_kind_e k;
      k = AccBad;
      if (a[31:16] == BASE_HI) begin
         if (a[15:0] == OFF_CTRL) begin
            k = AccCtrl;
         end else if (a[15:0] == OFF_CFG) begin
            k = AccCfg;
         end else if (a[15:0] == OFF_STATUS) begin
            k = AccStatus;
         end else if (a[15:0] == OFF_RESULT) begin
            k = AccResult;
         end else if (a[15:12] == PIX_REGION && a[11:10] != 2'b11) begin
            k = AccPix;
         end
      end
      return k;
   endfunction

   ahb_state_e           state_q, state_d;
   acc_kind_e            kind_q, acc_kind;
   logic [1:0]           ch_q;
   logic [PIX_AW-1:0]    paddr_q;
   logic [31:0]          cfg_q, cfg_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [LABEL_W-1:0]   result_q, result_d;
   logic [31:0]          hrdata_q;
   logic                 pix_done_q;
   logic                 accept;
   logic [31:0]          rd_data;
   logic                 unused_inputs;

   assign unused_inputs = ^{ahb_hsize_i, ahb_htrans_i[0]};

   // hready/hresp are pure functions of the data-phase state.
   assign ahb_hready_o = !(state_q == StRdPix || state_q == StErr1);
   assign ahb_hresp_o  = (state_q == StErr1 || state_q == StErr2);
   assign accept       = ahb_htrans_i[1] && ahb_hready_o;
   assign acc_kind     = decode(ahb_haddr_i);

   // Pixel read data is passed straight through in the cycle after the read strobe.
   assign ahb_hrdata_o = pix_done_q ? {24'b0, pix_rdata_i} : hrdata_q;

   assign start_o     = (state_q == StWrData) && (kind_q == AccCtrl) && ahb_hwdata_i[0];
   assign cfg_o       = cfg_q;
   assign pix_we_o    = (state_q == StWrData) && (kind_q == AccPix);
   assign pix_re_o    = (state_q == StRdPix);
   assign pix_ch_o    = ch_q;
   assign pix_addr_o  = paddr_q;
   assign pix_wdata_o = ahb_hwdata_i[7:0];

   // Register next values; start beats a coincident done.
   always_comb begin
      cfg_d    = cfg_q;
      busy_d   = busy_q;
      done_d   = done_q;
      result_d = result_q;
      if (state_q == StWrData && kind_q == AccCfg) begin
         cfg_d = ahb_hwdata_i;
      end
      if (start_o) begin
         busy_d = 1'b1;
         done_d = 1'b0;
      end else if (done_i) begin
         busy_d   = 1'b0;
         done_d   = 1'b1;
         result_d = label_i;
      end
   end

   // Reads use next-state values so a read pipelined behind a write sees the new data.
   always_comb begin
      rd_data = 32'b0;
      unique case (acc_kind)
         AccCfg:    rd_data = cfg_d;
         AccStatus: rd_data = {30'b0, busy_d, done_d};
         AccResult: rd_data = {{(32 - LABEL_W){1'b0}}, result_d};
         default:   rd_data = 32'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRdPix: state_d = StIdle;
         StErr1:  state_d = StErr2;
         default: begin
            state_d = StIdle;
            if (accept) begin
               if (acc_kind == AccBad) begin
                  state_d = StErr1;
               end else if (ahb_hwrite_i) begin
                  state_d = StWrData;
               end else if (acc_kind == AccPix) begin
                  state_d = StRdPix;
               end else begin
                  state_d = StRdReg;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         kind_q     <= AccBad;
         ch_q       <= 2'b0;
         paddr_q    <= '0;
         cfg_q      <= 32'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         hrdata_q   <= 32'b0;
         pix_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
         pix_done_q <= (state_q == StRdPix);
         if (accept) begin
            kind_q  <= acc_kind;
            ch_q    <= ahb_haddr_i[11:10];
            paddr_q <= ahb_haddr_i[PIX_AW-1:0];
            if (!ahb_hwrite_i && acc_kind != AccPix && acc_kind != AccBad) begin
               hrdata_q <= rd_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_ahb_classifier_regs.sv
module tb_ahb_classifier_regs;
   import ahb_lite_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] haddr = 32'b0;
   logic        hwrite = 1'b0;
   logic [1:0]  htrans = HTRANS_IDLE;
   logic [31:0] hwdata = 32'b0;
   logic        hready, hresp;
   logic [31:0] hrdata;
   logic        start;
   logic [31:0] cfg;
   logic        done = 1'b0;
   logic [4:0]  label = 5'd0;
   logic        pix_we, pix_re;
   logic [1:0]  pix_ch;
   logic [9:0]  pix_addr;
   logic [7:0]  pix_wdata;
   logic [7:0]  pix_rdata = 8'h00;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];      // expected read data
   logic [19:0] pix_exp_q[$];  // expected {ch, addr, wdata} of pixel writes
   logic [7:0]  mem [0:3071];

   ahb_classifier_regs #(
      .BASE_HI (16'h8000),
      .LABEL_W (5),
      .PIX_AW  (10)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ahb_haddr_i  (haddr),
      .ahb_hwrite_i (hwrite),
      .ahb_htrans_i (htrans),
      .ahb_hsize_i  (HSIZE_WORD),
      .ahb_hwdata_i (hwdata),
      .ahb_hready_o (hready),
      .ahb_hresp_o  (hresp),
      .ahb_hrdata_o (hrdata),
      .start_o      (start),
      .cfg_o        (cfg),
      .done_i       (done),
      .label_i      (label),
      .pix_we_o     (pix_we),
      .pix_re_o     (pix_re),
      .pix_ch_o     (pix_ch),
      .pix_addr_o   (pix_addr),
      .pix_wdata_o  (pix_wdata),
      .pix_rdata_i  (pix_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Core-side pixel buffer model: registered read, one cycle after pix_re.
   always @(posedge clk) begin
      if (pix_we === 1'b1) mem[int'(pix_ch) * 1024 + int'(pix_addr)] <= pix_wdata;
      if (pix_re === 1'b1) pix_rdata <= mem[int'(pix_ch) * 1024 + int'(pix_addr)];
   end

   always @(negedge clk) begin
      if (pix_we === 1'b1) begin
         if (pix_exp_q.size() == 0) check_eq("pix_we_unexpected", 32'(pix_we), 32'd0);
         else check_eq("pix_we", {12'b0, pix_ch, pix_addr, pix_wdata}, {12'b0, pix_exp_q.pop_front()});
      end
   end

   task automatic addr_phase(input logic [31:0] a, input logic w);
      bit ok;
      ok = 0;
      haddr = a; hwrite = w; htrans = HTRANS_NSEQ;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (hready) begin ok = 1; break; end
      end
      if (!ok) check_eq("addr_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      htrans = HTRANS_IDLE; hwrite = 1'b0;
   endtask

   task automatic data_phase(input logic [31:0] wd, input bit is_rd, input string tag,
                             output int waits, output logic first_resp, output logic resp);
      bit ok;
      ok = 0; waits = 0; first_resp = 1'b0;
      hwdata = wd;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 0) first_resp = hresp;
         if (hready) begin ok = 1; break; end
         waits++;
      end
      if (!ok) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      resp = hresp;
      if (is_rd) begin
         if (exp_q.size() == 0) check_eq({tag, "_noexp"}, 32'd0, 32'd1);
         else check_eq(tag, hrdata, exp_q.pop_front());
      end
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input string tag);
      int w; logic fr, r;
      addr_phase(a, 1'b1);
      data_phase(d, 1'b0, tag, w, fr, r);
      check_eq({tag, "_resp"}, 32'(r), 32'd0);
      check_eq({tag, "_waits"}, 32'(w), 32'd0);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp, input int exp_waits,
                     input string tag);
      int w; logic fr, r;
      exp_q.push_back(exp);
      addr_phase(a, 1'b0);
      data_phase(32'b0, 1'b1, tag, w, fr, r);
      check_eq({tag, "_resp"}, 32'(r), 32'd0);
      check_eq({tag, "_waits"}, 32'(w), 32'(exp_waits));
   endtask

   task automatic acc_err(input logic [31:0] a, input logic w_en, input string tag);
      int w; logic fr, r;
      addr_phase(a, w_en);
      data_phase(32'hDEAD_BEEF, 1'b0, tag, w, fr, r);
      check_eq({tag, "_first_resp"}, 32'(fr), 32'd1);
      check_eq({tag, "_waits"}, 32'(w), 32'd1);
      check_eq({tag, "_last_resp"}, 32'(r), 32'd1);
      @(negedge clk);
      check_eq({tag, "_okay_after"}, {30'b0, hready, hresp}, 32'h2);
   endtask

   initial begin
      for (int i = 0; i < 3072; i++) mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("rst_hready", 32'(hready), 32'd1);
      check_eq("rst_hresp", 32'(hresp), 32'd0);
      check_eq("rst_hrdata", hrdata, 32'd0);
      check_eq("rst_cfg", cfg, 32'd0);
      check_eq("rst_strobes", {29'b0, start, pix_we, pix_re}, 32'd0);

      // Back-to-back CFG write then read, never a wait state.
      @(posedge clk); #1;
      haddr = 32'h8000_0004; hwrite = 1'b1; htrans = HTRANS_NSEQ;
      @(negedge clk);
      check_eq("b2b_hready0", 32'(hready), 32'd1);
      @(posedge clk); #1;
      hwdata = 32'd32; hwrite = 1'b0; exp_q.push_back(32'd32);
      @(negedge clk);
      check_eq("b2b_hready1", 32'(hready), 32'd1);
      @(posedge clk); #1;
      htrans = HTRANS_IDLE;
      @(negedge clk);
      check_eq("b2b_hready2", 32'(hready), 32'd1);
      check_eq("b2b_cfg", cfg, 32'd32);
      check_eq("b2b_rd_cfg", hrdata, exp_q.pop_front());
      @(posedge clk); #1;

      // Pixel writes.
      pix_exp_q.push_back({2'd0, 10'd5, 8'hAB});
      wr(32'h8000_2005, 32'h0000_00AB, "pix_wr_r");
      pix_exp_q.push_back({2'd2, 10'd5, 8'h3C});
      wr(32'h8000_2805, 32'hFFFF_FF3C, "pix_wr_b");
      pix_exp_q.push_back({2'd1, 10'd5, 8'h5A});
      wr(32'h8000_2405, 32'h0000_005A, "pix_wr_g");

      // Start / done handshake.
      addr_phase(32'h8000_0000, 1'b1);
      hwdata = 32'd1;
      @(negedge clk);
      check_eq("start_pulse", 32'(start), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("start_one_cycle", 32'(start), 32'd0);
      @(posedge clk); #1;
      rd(32'h8000_1000, 32'd2, 0, "status_busy");
      done = 1'b1; label = 5'd7;
      @(posedge clk); #1;
      done = 1'b0;
      rd(32'h8000_1000, 32'd1, 0, "status_done");
      rd(32'h8000_1004, 32'd7, 0, "result_7");
      addr_phase(32'h8000_0000, 1'b1);
      hwdata = 32'd1; done = 1'b1; label = 5'd9;
      @(posedge clk); #1;
      done = 1'b0;
      rd(32'h8000_1000, 32'd2, 0, "status_start_wins");
      rd(32'h8000_1004, 32'd7, 0, "result_kept");
      wr(32'h8000_0000, 32'd0, "ctrl_wr0");
      rd(32'h8000_0000, 32'd0, 0, "ctrl_rd_zero");
      wr(32'h8000_1004, 32'd3, "result_wr_ignored");
      rd(32'h8000_1004, 32'd7, 0, "result_after_wr");

      // Pixel read: one wait cycle.
      rd(32'h8000_2405, 32'h0000_005A, 1, "pix_rd_g");
      rd(32'h8000_2805, 32'h0000_003C, 1, "pix_rd_b");

      // Error responses.
      acc_err(32'h8000_3000, 1'b0, "err_off");
      acc_err(32'h9000_0000, 1'b1, "err_base");
      acc_err(32'h8000_2C00, 1'b0, "err_pix_hole");

      // Transfer pipelined during ERR2 is accepted.
      addr_phase(32'h8000_3000, 1'b0);
      @(negedge clk);
      check_eq("err1_state", {30'b0, hready, hresp}, 32'h1);
      haddr = 32'h8000_0004; hwrite = 1'b0; htrans = HTRANS_NSEQ;
      exp_q.push_back(32'd32);
      @(negedge clk);
      check_eq("err2_state", {30'b0, hready, hresp}, 32'h3);
      @(posedge clk); #1;
      htrans = HTRANS_IDLE;
      @(negedge clk);
      check_eq("err2_pipe_resp", {30'b0, hready, hresp}, 32'h2);
      check_eq("err2_pipe_rd", hrdata, exp_q.pop_front());
      @(posedge clk); #1;

      // Reset during ERR1 aborts the transfer.
      addr_phase(32'h8000_3000, 1'b0);
      @(negedge clk);
      check_eq("pre_rst_err1", {30'b0, hready, hresp}, 32'h1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst_abort_resp", {30'b0, hready, hresp}, 32'h2);
      check_eq("rst_abort_cfg", cfg, 32'd0);
      @(posedge clk); #1;
      rd(32'h8000_1000, 32'd0, 0, "rst_abort_status");

      check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check_eq("pix_exp_q_empty", 32'(pix_exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
